axi_read_frame_fetch: RTL and testbench

AXI4 read-channel master that fetches a stored camera frame from frame memory in fixed-length INCR bursts and presents it as a valid/ready word stream to the object-detection datapath. It is the read-side counterpart of the camera write path: the camera writes frames into memory over AW/W/B, and this block reads them back over AR/R. Internal buffering and credit-based burst issue ensure no R beat is ever back-pressured by the downstream consumer.

---
 rtl/axi_read_frame_fetch.sv | 116 +++++++++++
 tb/tb_axi_read_frame_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_frame_fetch.sv
// axi_read_frame_fetch: AXI4 read master fetching a frame in fixed INCR bursts into a
// first-word fall-through stream buffer, issuing a burst only when the buffer can absorb it.
module axi_read_frame_fetch #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       num_bursts,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [7:0]        ARLEN,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(BURST_LEN + 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
   localparam logic [AW:0] CREDIT_MAX = (AW + 1)'(FIFO_DEPTH - BURST_LEN);
   localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(BURST_LEN * DATA_W / 8);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0] bursts_q, bursts_d;
   logic [BW-1:0] beat_q, beat_d;
   logic err_q, err_d, done_q, done_d;
   logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic r_fire, pix_fire, empty, last_beat;
   assign count     = wptr_q - rptr_q;
   assign empty     = count == '0;
   assign r_fire    = RVALID && RREADY;
   assign pix_fire  = pix_valid && pix_ready;
   assign last_beat = beat_q == LAST_BEAT;
   assign ARADDR    = addr_q;
   assign ARLEN     = 8'(BURST_LEN - 1);
   // a whole burst of space must already be free, so R beats never stall
   assign ARVALID   = state_q == ADDR && count <= CREDIT_MAX;
   assign RREADY    = state_q == DATA;
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign err       = err_q;
   assign pix_valid = !empty;
   assign pix_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      bursts_d = bursts_q;
      beat_d   = beat_q;
      err_d    = err_q;
      done_d   = 1'b0;
      wptr_d   = wptr_q + (AW + 1)'(r_fire);
      rptr_d   = rptr_q + (AW + 1)'(pix_fire);
      case (state_q)
         IDLE: if (start) begin
            addr_d   = base_addr;
            bursts_d = num_bursts;
            err_d    = 1'b0;
            state_d  = num_bursts == '0 ? DRAIN : ADDR;
         end
         ADDR: if (ARVALID && ARREADY) state_d = DATA;
         DATA: if (r_fire) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
            if (RRESP != 2'b00 || RLAST != last_beat) err_d = 1'b1;
            if (last_beat) begin
               bursts_d = bursts_q - 16'd1;
               addr_d   = addr_q + ADDR_INC;
               state_d  = bursts_q == 16'd1 ? DRAIN : ADDR;
            end
         end
         DRAIN: if (empty) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         bursts_q <= '0;
         beat_q   <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         wptr_q   <= '0;
         rptr_q   <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         bursts_q <= bursts_d;
         beat_q   <= beat_d;
         err_q    <= err_d;
         done_q   <= done_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
      end
   end
   always_ff @(posedge ACLK) begin
      if (r_fire) mem_q[wptr_q[AW-1:0]] <= RDATA;
   end
endmodule

// File: tb/tb_axi_read_frame_fetch.sv
// tb_axi_read_frame_fetch: directed bench with an AXI read slave model and a word scoreboard.
module tb_axi_read_frame_fetch;
   logic ACLK = 0, ARESET = 1, start = 0;
   logic [31:0] base_addr = 0;
   logic [15:0] num_bursts = 0;
   logic busy, done, err, ARVALID, RREADY, pix_valid;
   logic [31:0] ARADDR, pix_data;
   logic [7:0] ARLEN;
   logic ARREADY = 0, RLAST = 0, RVALID = 0, pix_ready = 0;
   logic [31:0] RDATA = 0;
   logic [1:0] RRESP = 0;

   axi_read_frame_fetch dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .base_addr(base_addr),
      .num_bursts(num_bursts), .busy(busy), .done(done), .err(err),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0, failures = 0;
   logic [31:0] sb[$];
   logic [31:0] exp_addr[$];
   int pops_allowed = -1, err_burst = -1, err_beat = -1, rlast_beat = -1;
   bit ar_rand = 0, rv_rand = 0, r_active = 0, done_seen = 0;
   logic [31:0] r_addr = 0, cur_exp = 0;
   int r_beat = 0, burst_idx = 0;
   int done_cnt = 0, words_popped = 0, beats_pushed = 0, ar_cnt = 0;
   logic err_at_done = 0;

   function automatic logic [31:0] word(logic [31:0] a, int b);
      return (a + 32'(b) * 4) ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Samples at the falling edge and drives inputs for the next rising edge.
   task automatic cycle();
      @(negedge ACLK);
      if (done) begin
         done_cnt++;
         done_seen = 1;
         err_at_done = err;
      end
      pix_ready = pops_allowed != 0;
      if (pix_valid && pix_ready) begin
         if (pops_allowed > 0) pops_allowed--;
         words_popped++;
         chk("sb_nonempty", 64'(sb.size() > 0), 1);
         if (sb.size() > 0) chk("pix_data", pix_data, sb.pop_front());
      end
      RVALID = 0;
      RLAST = 0;
      RRESP = 0;
      if (r_active && (!rv_rand || $urandom_range(0, 3) != 0)) begin
         RVALID = 1;
         RDATA = word(r_addr, r_beat);
         RRESP = (burst_idx == err_burst && r_beat == err_beat) ? 2'b10 : 2'b00;
         RLAST = rlast_beat >= 0 ? r_beat == rlast_beat : r_beat == 15;
         chk("rready_in_burst", RREADY, 1);
         if (RREADY) begin
            sb.push_back(word(cur_exp, r_beat));
            beats_pushed++;
            r_beat++;
            if (r_beat == 16) begin
               r_active = 0;
               burst_idx++;
            end
         end
      end
      ARREADY = !ar_rand || $urandom_range(0, 1) == 1;
      if (ARVALID && ARREADY) begin
         ar_cnt++;
         chk("ar_expected", 64'(exp_addr.size() > 0), 1);
         cur_exp = exp_addr.size() > 0 ? exp_addr.pop_front() : 'x;
         chk("araddr", ARADDR, cur_exp);
         r_active = 1;
         r_addr = ARADDR;
         r_beat = 0;
      end
   endtask

   task automatic chk_reset(string p);
      chk({p, "_arvalid"}, ARVALID, 0);
      chk({p, "_rready"}, RREADY, 0);
      chk({p, "_araddr"}, ARADDR, 0);
      chk({p, "_arlen"}, ARLEN, 15);
      chk({p, "_busy"}, busy, 0);
      chk({p, "_done"}, done, 0);
      chk({p, "_err"}, err, 0);
      chk({p, "_pix_valid"}, pix_valid, 0);
      chk({p, "_pix_data"}, pix_data, 0);
   endtask

   task automatic do_start(logic [31:0] b, int n);
      base_addr = b;
      num_bursts = 16'(n);
      start = 1;
      for (int k = 0; k < n; k++) exp_addr.push_back(b + 32'(k) * 64);
      done_seen = 0;
      done_cnt = 0;
      words_popped = 0;
      beats_pushed = 0;
      ar_cnt = 0;
      burst_idx = 0;
      err_at_done = 0;
      cycle();
      start = 0;
      chk("busy_after_start", busy, 1);
      chk("arvalid_t1", ARVALID, 64'(n != 0));
   endtask

   task automatic run_to_done(int budget);
      for (int i = 0; i < budget && !done_seen; i++) cycle();
      chk("done_within_budget", 64'(done_seen), 1);
      repeat (3) cycle();
   endtask

   task automatic finish_frame(string p, int n, logic e);
      chk({p, "_done_cnt"}, done_cnt, 1);
      chk({p, "_err_at_done"}, err_at_done, e);
      chk({p, "_words"}, words_popped, n * 16);
      chk({p, "_sb_empty"}, sb.size(), 0);
      chk({p, "_ar_cnt"}, ar_cnt, n);
      chk({p, "_busy"}, busy, 0);
   endtask

   initial begin
      repeat (3) cycle();
      chk_reset("rst");
      ARESET = 0;
      cycle();
      // basic frame, with a start pulse while busy that must be ignored
      do_start(32'h1000, 2);
      repeat (3) cycle();
      start = 1;
      base_addr = 32'hDEAD_0000;
      num_bursts = 5;
      cycle();
      start = 0;
      run_to_done(300);
      finish_frame("basic", 2, 0);
      // back-pressure: third burst waits for 16 free words
      pops_allowed = 0;
      do_start(32'h8000, 3);
      for (int i = 0; i < 400 && beats_pushed < 32; i++) cycle();
      repeat (10) cycle();
      chk("bp_two_bursts", ar_cnt, 2);
      chk("bp_arvalid_withheld", ARVALID, 0);
      pops_allowed = 15;
      repeat (20) cycle();
      chk("bp_popped15", words_popped, 15);
      chk("bp_still_withheld", ARVALID, 0);
      chk("bp_ar_cnt15", ar_cnt, 2);
      pops_allowed = 1;
      repeat (3) cycle();
      chk("bp_third_ar", ar_cnt, 3);
      pops_allowed = -1;
      run_to_done(400);
      finish_frame("bp", 3, 0);
      // error response on beat 5 of first burst, random handshakes
      err_burst = 0;
      err_beat = 4;
      rv_rand = 1;
      ar_rand = 1;
      do_start(32'h4000, 2);
      run_to_done(400);
      finish_frame("rresp", 2, 1);
      chk("err_sticky_idle", err, 1);
      err_burst = -1;
      // early RLAST; err cleared on new start
      rlast_beat = 9;
      do_start(32'h5000, 1);
      chk("err_cleared", err, 0);
      run_to_done(300);
      finish_frame("rlast", 1, 1);
      rlast_beat = -1;
      rv_rand = 0;
      ar_rand = 0;
      // zero bursts: done two cycles after start, no AR
      do_start(32'h6000, 0);
      chk("zero_done_t1", done, 0);
      cycle();
      chk("zero_done_t2", done, 1);
      chk("zero_busy_t2", busy, 0);
      repeat (2) cycle();
      chk("zero_done_cnt", done_cnt, 1);
      chk("zero_ar_cnt", ar_cnt, 0);
      // address wrap
      do_start(32'hFFFF_FFC0, 2);
      run_to_done(300);
      finish_frame("wrap", 2, 0);
      // reset during beat 8 of the first burst
      pops_allowed = 0;
      do_start(32'h2000, 2);
      for (int i = 0; i < 100 && !(r_active && r_beat == 8); i++) cycle();
      chk("mid_reached_beat8", 64'(r_active && r_beat == 8), 1);
      ARESET = 1;
      #1;
      RVALID = 0;
      r_active = 0;
      sb.delete();
      exp_addr.delete();
      chk_reset("mid_rst");
      cycle();
      chk_reset("mid_rst_edge");
      ARESET = 0;
      pops_allowed = -1;
      cycle();
      do_start(32'h3000, 1);
      run_to_done(300);
      finish_frame("after_rst", 1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
